bp_me_io_cmd_arbiter: RTL

- Parametrised N-channel successor to the fixed two-way cfg/nbf loader mux in the trace-demo bench.
- Arbitrates num_ch_p IO command sources (nbf loader, cfg loader, host probes, …) onto one IO command link.
- Tracks the source of every in-flight command in an in-order tag FIFO and routes each IO response back to its originating channel.
- Sits between the nonsynth loaders and the bp_me_cce_to_io_link_bidir endpoint.

---
 rtl/bp_me_io_cmd_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/bp_me_io_cmd_arbiter.sv
// Purpose: arbitrates num_ch_p IO command sources onto one link; an in-order tag FIFO routes each response back to its source.
// Latency: a grant (cmd_yumi_o) is followed 1 cycle later by cmd_v_o; responses are routed combinationally.
// Backpressure: single-entry output register waits on cmd_ready_i; grants stop at max_outstanding_p in flight; a response is held until its owner is ready.
// Optional macro BP_ME_IO_ARB_STATS_EN adds grant_count_o and full_stall_o counters.
module bp_me_io_cmd_arbiter #(
  parameter int num_ch_p          = 2,
  parameter int cmd_width_p       = 128,
  parameter int resp_width_p      = 128,
  parameter int max_outstanding_p = 8,
  parameter int rr_mode_p         = 1
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic [num_ch_p*cmd_width_p-1:0]        cmd_i,
  input  logic [num_ch_p-1:0]                    cmd_v_i,
  output logic [num_ch_p-1:0]                    cmd_yumi_o,
  output logic [cmd_width_p-1:0]                 cmd_o,
  output logic                                   cmd_v_o,
  input  logic                                   cmd_ready_i,
  input  logic [resp_width_p-1:0]                resp_i,
  input  logic                                   resp_v_i,
  output logic                                   resp_yumi_o,
  output logic [resp_width_p-1:0]                resp_o,
  output logic [num_ch_p-1:0]                    resp_v_o,
  input  logic [num_ch_p-1:0]                    resp_ready_i,
  output logic [$clog2(max_outstanding_p+1)-1:0] outstanding_o,
  output logic                                   error_o
`ifdef BP_ME_IO_ARB_STATS_EN
  ,
  output logic [num_ch_p*32-1:0]                 grant_count_o,
  output logic [31:0]                            full_stall_o
`endif
);

  localparam int tag_w_lp = (num_ch_p > 1) ? $clog2(num_ch_p) : 1;
  localparam int ptr_w_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
  localparam int cnt_w_lp = $clog2(max_outstanding_p + 1);

  logic [tag_w_lp-1:0] rr_ptr_r;
  logic [tag_w_lp-1:0] tag_mem [max_outstanding_p];
  logic [ptr_w_lp-1:0] wr_ptr_r;
  logic [ptr_w_lp-1:0] rd_ptr_r;
  logic [cnt_w_lp-1:0] count_r;
  logic                error_r;

  logic                slot_open;
  logic                fifo_empty;
  logic                fifo_full;
  logic                grant_found;
  logic                grant_v;
  logic                resp_pop;
  logic [tag_w_lp-1:0] grant_idx;
  logic [tag_w_lp-1:0] cand;
  logic [tag_w_lp-1:0] head_tag;

  // Wrap a FIFO pointer at the configured depth, which need not be a power of two.
  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    if (p == ptr_w_lp'(max_outstanding_p - 1)) return '0;
    else return p + 1'b1;
  endfunction

  assign slot_open     = ~cmd_v_o | cmd_ready_i;
  assign fifo_empty    = (count_r == '0);
  assign fifo_full     = (count_r == cnt_w_lp'(max_outstanding_p));
  assign head_tag      = tag_mem[rd_ptr_r];
  assign outstanding_o = count_r;
  assign error_o       = error_r;
  assign resp_o        = resp_i;

  // Pick the winning channel: round-robin starts one past the last winner, fixed priority starts at 0.
  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    cand        = '0;
    for (int i = 0; i < num_ch_p; i++) begin
      if (rr_mode_p != 0) cand = tag_w_lp'((int'(rr_ptr_r) + 1 + i) % num_ch_p);
      else                cand = tag_w_lp'(i);
      if (!grant_found && cmd_v_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Gating with reset_n_i keeps the combinational handshakes quiet while reset is held.
  assign grant_v  = reset_n_i & slot_open & ~fifo_full & grant_found;
  assign resp_pop = reset_n_i & resp_v_i & ~fifo_empty & resp_ready_i[head_tag];
  assign resp_yumi_o = resp_pop;

  // One-hot accept to the granted source.
  always_comb begin
    cmd_yumi_o = '0;
    if (grant_v) cmd_yumi_o[grant_idx] = 1'b1;
  end

  // Present the incoming response only to the channel that issued the oldest in-flight command.
  always_comb begin
    resp_v_o = '0;
    if (reset_n_i && resp_v_i && !fifo_empty) resp_v_o[head_tag] = 1'b1;
  end

  // Output register: reload on grant, otherwise drop valid once the held command transfers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cmd_v_o <= 1'b0;
      cmd_o   <= '0;
    end else if (slot_open) begin
      cmd_v_o <= grant_v;
      if (grant_v) cmd_o <= cmd_i[int'(grant_idx)*cmd_width_p +: cmd_width_p];
    end
  end

  // Round-robin pointer remembers the last winner; reset value makes channel 0 first.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) rr_ptr_r <= tag_w_lp'(num_ch_p - 1);
    else if (grant_v) rr_ptr_r <= grant_idx;
  end

  // Tag storage needs no reset: entries are only read while the count says they are valid.
  always_ff @(posedge clk_i) begin
    if (grant_v) tag_mem[wr_ptr_r] <= grant_idx;
  end

  // Tag FIFO pointers and in-flight count; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (grant_v)  wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (resp_pop) rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({grant_v, resp_pop})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky flag for a response that has no command to match it; the response itself is held.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) error_r <= 1'b0;
    else if (resp_v_i && fifo_empty) error_r <= 1'b1;
  end

`ifdef BP_ME_IO_ARB_STATS_EN
  // Saturating per-channel grant counters and a counter of cycles lost to a full tag FIFO.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      grant_count_o <= '0;
      full_stall_o  <= '0;
    end else begin
      for (int k = 0; k < num_ch_p; k++) begin
        if (cmd_yumi_o[k] && (grant_count_o[k*32 +: 32] != 32'hFFFF_FFFF))
          grant_count_o[k*32 +: 32] <= grant_count_o[k*32 +: 32] + 32'd1;
      end
      if ((|cmd_v_i) && slot_open && fifo_full && (full_stall_o != 32'hFFFF_FFFF))
        full_stall_o <= full_stall_o + 32'd1;
    end
  end
`endif

endmodule
